// File: rtl/memtest_controller_mc.sv
// memtest_controller_mc: multi-channel memtest sequencer. It sends size and seed beats,
// advances the seed on each pass, and counts and captures per-channel errors.
// Ports: clk/reset (sync, active-high); avs_control_* Avalon-MM slave with 1-cycle read;
//   asi_pktstatus/done/comperr_* per-channel inputs; aso_seed_*, aso_size_* ready/valid streams.
// Optional: define MEMTEST_IRQ_EN to add output irq and the IRQ_EN register at word 8.
module memtest_controller_mc #(
    parameter int          NUM_CH    = 2,
    parameter int          DATA_W    = 128,
    parameter logic [31:0] SEED_STEP = 32'h9E3779B9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     avs_control_read,
    input  logic                     avs_control_write,
    input  logic [5:0]               avs_control_address,
    input  logic [31:0]              avs_control_writedata,
    output logic [31:0]              avs_control_readdata,
    input  logic [4*NUM_CH-1:0]      asi_pktstatus_data,
    input  logic [NUM_CH-1:0]        asi_done_valid,
    input  logic [NUM_CH-1:0]        asi_comperr_valid,
    input  logic [NUM_CH*DATA_W-1:0] asi_comperr_data,
    output logic                     aso_seed_valid,
    input  logic                     aso_seed_ready,
    output logic [127:0]             aso_seed_data,
    output logic                     aso_size_valid,
    input  logic                     aso_size_ready,
    output logic [31:0]              aso_size_data
`ifdef MEMTEST_IRQ_EN
    ,
    output logic                     irq
`endif
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_SIZE = 3'd1,
        S_LOAD_SEED = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            r_state;
    logic [31:0]       r_size, r_target, r_wsize, r_rdata;
    logic [31:0]       r_seed [4];
    logic [127:0]      r_wseed;
    logic [15:0]       r_pass_cnt;
    logic              r_cont, r_stop_pend, r_size_valid, r_seed_valid;
    logic [NUM_CH-1:0] r_done_mask, r_sticky;
    logic [31:0]       r_err_cnt   [NUM_CH];
    logic [31:0]       r_err_fold  [NUM_CH];
    logic [31:0]       r_err_word0 [NUM_CH];

    logic              w_wr_ctrl, w_start, w_stop, w_clr;
    logic [NUM_CH-1:0] w_mask, w_err_ev;
    logic              w_all, w_more, w_enter_done;
    logic [15:0]       w_pass_nx;
    logic [31:0]       w_target_eff, w_rdata;
    logic [31:0]       w_fold [NUM_CH];
    logic [7:0]        w_sticky8;

    assign w_wr_ctrl    = avs_control_write && (avs_control_address == 6'd1);
    assign w_start      = w_wr_ctrl && avs_control_writedata[0];
    assign w_stop       = w_wr_ctrl && avs_control_writedata[1];
    assign w_clr        = w_wr_ctrl && avs_control_writedata[3];
    assign w_mask       = r_done_mask | asi_done_valid;
    assign w_all        = &w_mask;
    assign w_pass_nx    = r_pass_cnt + 16'd1;
    assign w_target_eff = (r_target == 32'd0) ? 32'd1 : r_target;
    assign w_more       = r_cont || ({16'd0, w_pass_nx} < w_target_eff);
    // A STOP written in the very cycle the pass completes still counts.
    assign w_enter_done = (r_state == S_RUN) && w_all && !(r_stop_pend || w_stop) && !w_more;

    assign aso_size_valid       = r_size_valid;
    assign aso_size_data        = r_wsize;
    assign aso_seed_valid       = r_seed_valid;
    assign aso_seed_data        = r_wseed;
    assign avs_control_readdata = r_rdata;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_fold[ch] = '0;
            for (int l = 0; l < DATA_W / 32; l++)
                w_fold[ch] = w_fold[ch] | asi_comperr_data[ch*DATA_W + 32*l +: 32];
            w_err_ev[ch] = asi_comperr_valid[ch] && |asi_comperr_data[ch*DATA_W +: DATA_W];
        end
    end

    // Configuration registers; running passes use the working copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size   <= '0;
            r_target <= '0;
            r_cont   <= 1'b0;
            for (int i = 0; i < 4; i++) r_seed[i] <= '0;
        end else if (avs_control_write) begin
            case (avs_control_address)
                6'd1:    r_cont   <= avs_control_writedata[2];
                6'd2:    r_size   <= avs_control_writedata;
                6'd3:    r_target <= avs_control_writedata;
                6'd4:    r_seed[0] <= avs_control_writedata;
                6'd5:    r_seed[1] <= avs_control_writedata;
                6'd6:    r_seed[2] <= avs_control_writedata;
                6'd7:    r_seed[3] <= avs_control_writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pass_cnt   <= '0;
            r_wseed      <= '0;
            r_wsize      <= '0;
            r_stop_pend  <= 1'b0;
            r_done_mask  <= '0;
            r_size_valid <= 1'b0;
            r_seed_valid <= 1'b0;
        end else begin
            // STOP is only remembered while a run is in progress.
            if (w_stop)
                r_stop_pend <= (r_state != S_IDLE) && (r_state != S_DONE);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state      <= S_LOAD_SIZE;
                        r_pass_cnt   <= '0;
                        r_wseed      <= {r_seed[3], r_seed[2], r_seed[1], r_seed[0]};
                        r_wsize      <= r_size;
                        r_size_valid <= 1'b1;
                    end
                end
                S_LOAD_SIZE: begin
                    if (aso_size_ready) begin
                        r_size_valid <= 1'b0;
                        r_seed_valid <= 1'b1;
                        r_state      <= S_LOAD_SEED;
                    end
                end
                S_LOAD_SEED: begin
                    if (aso_seed_ready) begin
                        r_seed_valid <= 1'b0;
                        r_done_mask  <= '0;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_all) begin
                        r_pass_cnt  <= w_pass_nx;
                        r_done_mask <= '0;
                        if (r_stop_pend || w_stop) begin
                            r_state     <= S_IDLE;
                            r_stop_pend <= 1'b0;
                        end else if (w_more) begin
                            r_wseed[31:0] <= r_wseed[31:0] + SEED_STEP;
                            r_wsize       <= r_size;
                            r_size_valid  <= 1'b1;
                            r_state       <= S_LOAD_SIZE;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_done_mask <= w_mask;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Clear wins over an error arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || w_clr) begin
            r_sticky <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_err_cnt[ch]   <= '0;
                r_err_fold[ch]  <= '0;
                r_err_word0[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_err_ev[ch]) begin
                    if (r_err_cnt[ch] != 32'hFFFF_FFFF)
                        r_err_cnt[ch] <= r_err_cnt[ch] + 32'd1;
                    r_sticky[ch]    <= 1'b1;
                    r_err_fold[ch]  <= w_fold[ch];
                    r_err_word0[ch] <= asi_comperr_data[ch*DATA_W +: 32];
                end
            end
        end
    end

`ifdef MEMTEST_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_done_flag;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en    <= '0;
            r_done_flag <= 1'b0;
        end else begin
            if (avs_control_write && avs_control_address == 6'd8)
                r_irq_en <= avs_control_writedata[1:0];
            if (w_enter_done)
                r_done_flag <= 1'b1;
            else if (avs_control_read && avs_control_address == 6'd0)
                r_done_flag <= 1'b0;
        end
    end
    assign irq = (r_done_flag & r_irq_en[0]) | ((|r_sticky) & r_irq_en[1]);
`else
    logic w_unused;
    assign w_unused = w_enter_done;
`endif

    always_comb begin
        w_sticky8 = '0;
        w_sticky8[NUM_CH-1:0] = r_sticky;
    end

    always_comb begin
        w_rdata = '0;
        case (avs_control_address)
            6'd0: w_rdata = {r_pass_cnt, w_sticky8, 5'd0, r_state};
            6'd1: w_rdata = {29'd0, r_cont, 2'b00};
            6'd2: w_rdata = r_size;
            6'd3: w_rdata = r_target;
            6'd4: w_rdata = r_seed[0];
            6'd5: w_rdata = r_seed[1];
            6'd6: w_rdata = r_seed[2];
            6'd7: w_rdata = r_seed[3];
`ifdef MEMTEST_IRQ_EN
            6'd8: w_rdata = {30'd0, r_irq_en};
`endif
            default: begin
                if (avs_control_address[5]) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (avs_control_address[4:2] == 3'(ch)) begin
                            case (avs_control_address[1:0])
                                2'd0: w_rdata = r_err_cnt[ch];
                                2'd1: w_rdata = r_err_fold[ch];
                                2'd2: w_rdata = r_err_word0[ch];
                                default: w_rdata = {28'd0, asi_pktstatus_data[4*ch +: 4]};
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_rdata <= '0;
        else if (avs_control_read)
            r_rdata <= w_rdata;
    end
endmodule

// File: tb/tb_memtest_controller_mc.sv
// tb_memtest_controller_mc: scoreboard bench for memtest_controller_mc.
// Expected reads, size beats and seed beats are queued; monitors pop and compare.
module tb_memtest_controller_mc;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 128;

    logic                     clk = 0;
    logic                     reset = 1;
    logic                     avs_control_read = 0;
    logic                     avs_control_write = 0;
    logic [5:0]               avs_control_address = 0;
    logic [31:0]              avs_control_writedata = 0;
    logic [31:0]              avs_control_readdata;
    logic [4*NUM_CH-1:0]      asi_pktstatus_data = 0;
    logic [NUM_CH-1:0]        asi_done_valid = 0;
    logic [NUM_CH-1:0]        asi_comperr_valid = 0;
    logic [NUM_CH*DATA_W-1:0] asi_comperr_data = 0;
    logic                     aso_seed_valid;
    logic                     aso_seed_ready = 1;
    logic [127:0]             aso_seed_data;
    logic                     aso_size_valid;
    logic                     aso_size_ready = 1;
    logic [31:0]              aso_size_data;

    memtest_controller_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .avs_control_read(avs_control_read),
        .avs_control_write(avs_control_write),
        .avs_control_address(avs_control_address),
        .avs_control_writedata(avs_control_writedata),
        .avs_control_readdata(avs_control_readdata),
        .asi_pktstatus_data(asi_pktstatus_data),
        .asi_done_valid(asi_done_valid),
        .asi_comperr_valid(asi_comperr_valid),
        .asi_comperr_data(asi_comperr_data),
        .aso_seed_valid(aso_seed_valid),
        .aso_seed_ready(aso_seed_ready),
        .aso_seed_data(aso_seed_data),
        .aso_size_valid(aso_size_valid),
        .aso_size_ready(aso_size_ready),
        .aso_size_data(aso_size_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int seed_beats = 0;
    logic rd_d = 0;
    logic [31:0]  rd_q[$];
    logic [31:0]  size_q[$];
    logic [127:0] seed_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_d <= avs_control_read;

    // Read-data monitor
    always @(negedge clk) begin
        if (rd_d) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check("readdata", {96'd0, avs_control_readdata}, {96'd0, rd_q.pop_front()});
        end
    end

    // Stream monitors: a beat transfers on the edge following valid&ready
    always @(negedge clk) begin
        if (aso_size_valid && aso_size_ready) begin
            if (size_q.size() == 0) check("size_unexpected", 1, 0);
            else check("size_beat", {96'd0, aso_size_data}, {96'd0, size_q.pop_front()});
        end
        if (aso_seed_valid && aso_seed_ready) begin
            seed_beats++;
            if (seed_q.size() == 0) check("seed_unexpected", 1, 0);
            else check("seed_beat", aso_seed_data, seed_q.pop_front());
        end
    end

    // Generator model: after each seed beat, channels report done on separate cycles
    initial begin
        forever begin
            @(negedge clk);
            if (aso_seed_valid && aso_seed_ready && !reset) begin
                @(posedge clk); #1;
                repeat (2) @(posedge clk);
                #1 asi_done_valid = 2'b01;
                @(posedge clk); #1 asi_done_valid = 2'b10;
                @(posedge clk); #1 asi_done_valid = 2'b00;
            end
        end
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        avs_control_write = 1; avs_control_address = a; avs_control_writedata = d;
        @(posedge clk); #1;
        avs_control_write = 0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        avs_control_read = 1; avs_control_address = a;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        avs_control_read = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int base;
        logic [127:0] held;
        idle(3);
        check("rst_size_valid", aso_size_valid, 0);
        check("rst_seed_valid", aso_seed_valid, 0);
        check("rst_readdata", avs_control_readdata, 0);
        reset = 0;
        rd(6'd0, 32'h0);

        // Three counted passes
        wr(6'd2, 32'h1000);
        wr(6'd3, 32'd3);
        wr(6'd4, 32'd1); wr(6'd5, 32'd2); wr(6'd6, 32'd3); wr(6'd7, 32'd4);
        rd(6'd2, 32'h1000);
        rd(6'd5, 32'd2);
        repeat (3) size_q.push_back(32'h1000);
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'h0000_0001});
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'h9E37_79BA});
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'h3C6E_F373});
        wr(6'd1, 32'h1);
        idle(80);
        rd(6'd0, 32'h0003_0004);
        check("run3_size_q_empty", size_q.size(), 0);
        check("run3_seed_q_empty", seed_q.size(), 0);

        // PASS_TARGET 0 behaves as 1
        wr(6'd3, 32'd0);
        size_q.push_back(32'h1000);
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
        wr(6'd1, 32'h1);
        idle(40);
        rd(6'd0, 32'h0001_0004);

        // Seed stream back-pressure
        wr(6'd3, 32'd1);
        aso_seed_ready = 0;
        size_q.push_back(32'h1000);
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
        wr(6'd1, 32'h1);
        idle(3);
        held = aso_seed_data;
        check("stall_valid_start", aso_seed_valid, 1);
        idle(10);
        check("stall_valid_end", aso_seed_valid, 1);
        check("stall_data_stable", aso_seed_data, held);
        check("stall_data_value", aso_seed_data, {32'd4, 32'd3, 32'd2, 32'd1});
        rd(6'd0, 32'h0000_0002);
        aso_seed_ready = 1;
        idle(40);
        rd(6'd0, 32'h0001_0004);

        // Continuous run stopped during pass 2
        base = seed_beats;
        repeat (2) size_q.push_back(32'h1000);
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'h0000_0001});
        seed_q.push_back({32'd4, 32'd3, 32'd2, 32'h9E37_79BA});
        wr(6'd1, 32'h5);
        t = 0;
        while (seed_beats < base + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("cont_pass2_reached", seed_beats >= base + 2, 1);
        wr(6'd1, 32'h6);
        idle(40);
        rd(6'd0, 32'h0002_0000);
        check("cont_size_q_empty", size_q.size(), 0);
        check("cont_seed_q_empty", seed_q.size(), 0);

        // Two channel-1 errors at bit 40; zero-data valid on ch0 is ignored
        asi_pktstatus_data = 8'hA5;
        @(posedge clk); #1;
        asi_comperr_valid = 2'b11;
        asi_comperr_data = '0;
        asi_comperr_data[DATA_W + 40] = 1'b1;
        idle(2);
        asi_comperr_valid = 2'b00;
        rd(6'h24, 32'd2);
        rd(6'h25, 32'h100);
        rd(6'h26, 32'h0);
        rd(6'h20, 32'd0);
        rd(6'h21, 32'd0);
        rd(6'h23, 32'h5);
        rd(6'h27, 32'hA);
        rd(6'h28, 32'h0);
        rd(6'd9, 32'h0);
        rd(6'd0, 32'h0002_0200);

        // Clear in the same cycle as an error: clear wins
        @(posedge clk); #1;
        avs_control_write = 1; avs_control_address = 6'd1; avs_control_writedata = 32'h8;
        asi_comperr_valid = 2'b10;
        @(posedge clk); #1;
        avs_control_write = 0;
        asi_comperr_valid = 2'b00;
        rd(6'h24, 32'd0);
        rd(6'h25, 32'd0);
        rd(6'd0, 32'h0002_0000);

        // Reset while the size stream is stalled with valid high
        asi_comperr_data = '0;
        asi_comperr_data[3] = 1'b1;
        asi_comperr_valid = 2'b01;
        idle(1);
        asi_comperr_valid = 2'b00;
        rd(6'h20, 32'd1);
        aso_size_ready = 0;
        wr(6'd1, 32'h1);
        idle(3);
        check("pre_reset_size_valid", aso_size_valid, 1);
        reset = 1;
        idle(1);
        reset = 0;
        check("post_reset_size_valid", aso_size_valid, 0);
        check("post_reset_seed_valid", aso_seed_valid, 0);
        check("post_reset_readdata", avs_control_readdata, 0);
        aso_size_ready = 1;
        rd(6'd0, 32'h0);
        rd(6'h20, 32'h0);
        rd(6'd2, 32'h0);
        rd(6'd4, 32'h0);
        idle(10);
        check("final_rd_q_empty", rd_q.size(), 0);
        check("final_size_q_empty", size_q.size(), 0);
        check("final_seed_q_empty", seed_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
